cr_burst_reader: RTL
====================

// Module: cr_burst_reader
// PURPOSE
//  Credit-gated burst read engine: accepts {len,addr} requests, issues len consecutive reads to a
//  fixed-latency RAM, buffers returned words in an internal FWFT FIFO and emits them as a stream
//  with tlast on the final beat of each burst. Credit counter sized to the FIFO guarantees no overflow
//  under any output back-pressure. Generalises the RAM0/RAM1 credit chain into one parametrised stage.
// PARAMETERS
//  ADDR_W      8   RAM address width; burst addresses wrap modulo 2**ADDR_W
//  DATA_W      16  RAM / output data width
//  LEN_W       4   burst length field width; len==0 encodes 2**LEN_W beats
//  FIFO_DEPTH  32  output FIFO depth, power of 2, >= 2**LEN_W
//  RD_LATENCY  2   RAM read latency in cycles (mem_read -> mem_valid), >= 1
// PORTS
//  clk         in   1               clock
//  reset_p     in   1               synchronous active-high reset
//  s_tdata     in   LEN_W+ADDR_W    request {len, addr}
//  s_tvalid    in   1               request valid
//  s_tready    out  1               request accepted when s_tvalid & s_tready
//  mem_addr    out  ADDR_W          RAM read address (registered)
//  mem_read    out  1               RAM read strobe (registered)
//  mem_data    in   DATA_W          RAM read data
//  mem_valid   in   1               RAM read data valid
//  m_tdata     out  DATA_W          output data (FIFO head)
//  m_tvalid    out  1               output valid = FIFO not empty
//  m_tready    in   1               output ready
//  m_tlast     out  1               last beat of burst
//  credit_cnt  out  $clog2(FIFO_DEPTH)+1  free credits
//  overflow    out  1               sticky: FIFO written while full
//  rd_err      out  1               sticky: mem_valid without matching read RAM_LATENCY earlier
// BEHAVIOUR
//  - Reset (reset_p=1, sampled at clk): credit_cnt=FIFO_DEPTH, FSM=IDLE, FIFO empty, mem_read=0,
//    mem_addr=0, m_tvalid=0, m_tlast=0, overflow=0, rd_err=0, s_tready=0 during reset.
//  - beats(len) = (len==0) ? 2**LEN_W : len.
//  - s_tready = (FSM==IDLE) & (credit_cnt >= beats(s_tdata.len)) & ~reset_p.
//  - credit_cnt next = credit_cnt - (accept ? beats : 0) + (m_tvalid & m_tready); both in one cycle allowed.
//    credit_cnt never exceeds FIFO_DEPTH; exceeding is a design error (assertion).
//  - FSM IDLE: on accept latch addr, beats -> ISSUE. ISSUE: mem_read=1 for exactly beats consecutive
//    cycles, mem_addr = addr, addr+1, ... wrapping; on last issued beat -> IDLE. One idle cycle between
//    bursts (accept at T, reads T+1..T+N, next accept earliest T+N+1).
//  - Last-flag pipeline: shift register of RD_LATENCY stages carrying {read, last}; when mem_valid=1,
//    {mem_data, last} written to FIFO. mem_valid=1 with delayed read=0 sets rd_err (sticky);
//    delayed read=1 with mem_valid=0 also sets rd_err.
//  - Latency: mem_valid at cycle C -> m_tvalid/m_tdata visible at C+1 (registered FIFO write, FWFT read).
//  - m_tvalid/m_tdata/m_tlast held stable while m_tvalid & ~m_tready.
//  - FIFO write when full: word dropped, overflow set (sticky until reset).
//  - Reset mid-burst: issue aborted, FIFO flushed, credits reloaded; for RD_LATENCY cycles after
//    reset_p falls mem_valid is ignored (not written, rd_err not set).
// STRUCTURE
//  - Package cr_pkg: function cr_beats(len, LEN_W); typedef cr_state_t {CR_IDLE, CR_ISSUE}.
//  - Sub-module cr_sync_fifo #(WIDTH, DEPTH): FWFT sync FIFO, reset_p sync, ports din/wr_en/rd_en/
//    dout/full/empty; instantiated with WIDTH=DATA_W+1 (tlast in MSB).
//  - FSM, credit counter, last-flag pipeline and sticky flags in cr_burst_reader.
// TESTING (defaults, RD_LATENCY=2)
//  - Reset 3 cycles -> credit_cnt=32, s_tready=1 after release, m_tvalid=0, mem_read=0, flags 0.
//  - Req len=1 addr=0x10, m_tready=1 -> one mem_read addr 0x10; data out with m_tlast=1; credit_cnt 31->32.
//  - Req len=0 addr=0xF8 -> 16 reads F8..FF,00..07 back-to-back; m_tlast only on 16th beat.
//  - m_tready=0, reqs len=0 then len=15 -> credit_cnt=1; req len=2 held s_tready=0; pop 1 -> accepted,
//    overflow stays 0, FIFO reaches 32 words max.
//  - Accept len=4 in same cycle as one pop with credit_cnt=20 -> credit_cnt=17 next cycle.
//  - reset_p pulse mid 16-beat burst, RAM still returns data -> FIFO empty, rd_err=0, credit_cnt=32;
//    later stray mem_valid with no read -> rd_err=1 and stays 1.

Source files
------------

// File: rtl/cr_pkg.sv
// Shared types and helpers for the credit-gated burst reader.
package cr_pkg;

    typedef enum logic {CR_IDLE, CR_ISSUE} cr_state_t;

    // A zero length field encodes the maximum burst of 2**len_w beats.
    function automatic int unsigned cr_beats(input int unsigned len, input int unsigned len_w);
        return (len == 0) ? (32'd1 << len_w) : len;
    endfunction

endpackage

// File: rtl/cr_sync_fifo.sv
// First-word-fall-through synchronous FIFO; writes while full are dropped.
module cr_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cr_burst_reader.sv
// Credit-gated burst read engine: issues consecutive RAM reads per request and
// streams the returned words out of a FIFO with tlast on each burst's final beat.
module cr_burst_reader
    import cr_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset_p,
    input  logic [LEN_W+ADDR_W-1:0]         s_tdata,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_read,
    input  logic [DATA_W-1:0]               mem_data,
    input  logic                            mem_valid,
    output logic [DATA_W-1:0]               m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]     credit_cnt,
    output logic                            overflow,
    output logic                            rd_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(RD_LATENCY + 1);

    logic [LEN_W-1:0]  req_len;
    logic [ADDR_W-1:0] req_addr;
    logic [CW-1:0]     req_beats;
    logic              accept, pop;

    cr_state_t         state, state_d;
    logic [LEN_W:0]    remain, remain_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_read_d, cur_last;

    logic [RD_LATENCY:1] vld_pipe, last_pipe;
    logic [LW-1:0]       ign_cnt;
    logic                ram_ok, fifo_wr, fifo_full, fifo_empty;
    logic [DATA_W:0]     fifo_dout;

    assign {req_len, req_addr} = s_tdata;
    assign req_beats = CW'(cr_beats(32'(req_len), LEN_W));
    assign s_tready  = (state == CR_IDLE) && (credit_cnt >= req_beats) && !reset_p;
    assign accept    = s_tvalid && s_tready;
    assign pop       = m_tvalid && m_tready;
    // The beat going out right now closes the burst when nothing remains after it.
    assign cur_last  = (state == CR_ISSUE) && (remain == '0);

    always_comb begin
        state_d    = state;
        remain_d   = remain;
        mem_read_d = 1'b0;
        mem_addr_d = mem_addr;
        case (state)
            CR_IDLE: if (accept) begin
                state_d    = CR_ISSUE;
                mem_read_d = 1'b1;
                mem_addr_d = req_addr;
                remain_d   = (LEN_W+1)'(req_beats - CW'(1));
            end
            CR_ISSUE: if (remain == '0) begin
                state_d = CR_IDLE;
            end else begin
                mem_read_d = 1'b1;
                mem_addr_d = mem_addr + ADDR_W'(1);
                remain_d   = remain - 1'b1;
            end
            default: state_d = CR_IDLE;
        endcase
    end

    // Responses to reads issued before reset may still arrive; ignore them
    // until the (cleared) read pipeline has caught up.
    assign ram_ok  = (ign_cnt == '0);
    assign fifo_wr = mem_valid && ram_ok;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state      <= CR_IDLE;
            remain     <= '0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            credit_cnt <= CW'(FIFO_DEPTH);
            vld_pipe   <= '0;
            last_pipe  <= '0;
            ign_cnt    <= LW'(RD_LATENCY);
            overflow   <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            state      <= state_d;
            remain     <= remain_d;
            mem_read   <= mem_read_d;
            mem_addr   <= mem_addr_d;
            credit_cnt <= credit_cnt - (accept ? req_beats : CW'(0)) + CW'(pop);
            vld_pipe[1]  <= mem_read;
            last_pipe[1] <= cur_last;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            if (ign_cnt != '0) ign_cnt <= ign_cnt - 1'b1;
            if (fifo_wr && fifo_full) overflow <= 1'b1;
            if (ram_ok && (mem_valid != vld_pipe[RD_LATENCY])) rd_err <= 1'b1;
        end
    end

    cr_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_p (reset_p),
        .din     ({last_pipe[RD_LATENCY], mem_data}),
        .wr_en   (fifo_wr),
        .rd_en   (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_dout[DATA_W-1:0];
    assign m_tlast  = !fifo_empty && fifo_dout[DATA_W];

    a_credit_bound: assert property (@(posedge clk) disable iff (reset_p)
        credit_cnt <= CW'(FIFO_DEPTH));

endmodule
